// File: rtl/rv32i_types.sv
// ----------------------------------------------------------------------------
// rv32i_types
// Shared types for the out-of-order core's result-broadcast path.
//   cdb_t         : common-data-bus packet (valid, ROB tag, dest phys reg, data)
//   funct_unit_t  : functional-unit classes; the encoding is the CDB requester
//                   index used by cdb_arbiter
//   NUM_CDB_REQ   : number of units that compete for the CDB
//   cdb_req_arr_t : one cdb_t per requester
// ----------------------------------------------------------------------------
package rv32i_types;

    localparam int XLEN          = 32;
    localparam int ROB_IDX_WIDTH = 6;
    localparam int PRF_IDX_WIDTH = 7;

    // Qualifier for broadcast packets
    typedef enum logic {
        INVALID = 1'b0,
        VALID   = 1'b1
    } valid_t;

    // Requester index on the CDB equals this encoding
    typedef enum logic [1:0] {
        ARITH_UNIT   = 2'd0,
        MEM_UNIT     = 2'd1,
        BR_UNIT      = 2'd2,
        MUL_DIV_UNIT = 2'd3
    } funct_unit_t;

    typedef struct packed {
        valid_t                   valid;
        logic [ROB_IDX_WIDTH-1:0] rob_addr;
        logic [PRF_IDX_WIDTH-1:0] rd_paddr;
        logic [XLEN-1:0]          rd_data;
    } cdb_t;

    localparam int NUM_CDB_REQ = 4;

    typedef cdb_t [NUM_CDB_REQ-1:0] cdb_req_arr_t;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Scans req_i starting at ptr_i and
// wrapping modulo NUM_REQ; the first set request wins.
//   req_i         : request vector
//   ptr_i         : index with the highest priority this cycle (< NUM_REQ)
//   grant_o       : one-hot grant, zero if no request
//   grant_idx_o   : encoded index of the winner (0 if none)
//   grant_valid_o : a request was granted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [IDX_WIDTH-1:0] grant_idx_o,
    output logic                 grant_valid_o
);

    // Walk the requesters from ptr_i onward. The sum carries one extra bit so
    // the wrap is an explicit compare against NUM_REQ, which keeps the
    // ordering correct when NUM_REQ is not a power of two.
    always_comb begin
        logic [IDX_WIDTH:0]   sum;
        logic [IDX_WIDTH-1:0] idx;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        sum           = '0;
        idx           = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr_i} + (IDX_WIDTH+1)'(off);
            if (sum >= (IDX_WIDTH+1)'(NUM_REQ)) begin
                sum = sum - (IDX_WIDTH+1)'(NUM_REQ);
            end
            idx = sum[IDX_WIDTH-1:0];
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
// Shares the single common data bus between the functional units. Every unit
// owns a one-entry holding slot filled through a valid/ready handshake; each
// cycle one occupied slot is picked round-robin and registered onto the CDB.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : mispredict flush, drops every pending result
//   fu_valid   : per-unit result valid
//   fu_ready   : per-unit slot can accept this cycle
//   fu_result  : per-unit result packet (its valid field is ignored)
//   cdb        : registered broadcast, qualified by cdb.valid
//   cdb_grant  : registered one-hot source of the current cdb
// ----------------------------------------------------------------------------
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_REQ       = NUM_CDB_REQ,
    parameter int REQ_IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NUM_REQ-1:0]   fu_valid,
    output logic [NUM_REQ-1:0]   fu_ready,
    input  cdb_t [NUM_REQ-1:0]   fu_result,
    output cdb_t                 cdb,
    output logic [NUM_REQ-1:0]   cdb_grant
);

    cdb_t [NUM_REQ-1:0]     slot_q,       slot_d;
    logic [NUM_REQ-1:0]     slot_valid_q, slot_valid_d;
    logic [REQ_IDX_WIDTH-1:0] rr_ptr_q,   rr_ptr_d;
    cdb_t                   cdb_q,        cdb_d;
    logic [NUM_REQ-1:0]     cdb_grant_q,  cdb_grant_d;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       grant;
    logic [REQ_IDX_WIDTH-1:0] grant_idx;
    logic                     grant_valid;

    // A flush suppresses the grant, so nothing is broadcast on a flush edge.
    assign req = flush ? '0 : slot_valid_q;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (REQ_IDX_WIDTH)
    ) u_rr_arbiter (
        .req_i         (req),
        .ptr_i         (rr_ptr_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // A slot can take a new packet when empty or when it is draining this
    // cycle. rst gates ready so units see 0 while reset is held.
    assign fu_ready = {NUM_REQ{~rst & ~flush}} & (~slot_valid_q | grant);

    // Next-state for slots, pointer and the CDB register. A granted slot is
    // freed unless refilled on the same edge; flush overrides everything.
    always_comb begin
        slot_d       = slot_q;
        slot_valid_d = slot_valid_q;
        rr_ptr_d     = rr_ptr_q;
        cdb_d        = cdb_q;
        cdb_d.valid  = INVALID;
        cdb_grant_d  = '0;
        if (flush) begin
            slot_valid_d = '0;
            rr_ptr_d     = '0;
        end else begin
            if (grant_valid) begin
                cdb_d                   = slot_q[grant_idx];
                cdb_d.valid             = VALID;
                cdb_grant_d             = grant;
                slot_valid_d[grant_idx] = 1'b0;
                rr_ptr_d = (grant_idx == REQ_IDX_WIDTH'(NUM_REQ-1))
                         ? '0 : grant_idx + REQ_IDX_WIDTH'(1);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    slot_d[i]       = fu_result[i];
                    slot_valid_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset to an empty, idle bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= '0;
            slot_valid_q <= '0;
            rr_ptr_q     <= '0;
            cdb_q        <= '0;
            cdb_grant_q  <= '0;
        end else begin
            slot_q       <= slot_d;
            slot_valid_q <= slot_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_q        <= cdb_d;
            cdb_grant_q  <= cdb_grant_d;
        end
    end

    assign cdb       = cdb_q;
    assign cdb_grant = cdb_grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed, table-driven bench for cdb_arbiter plus hand-written sequences
// for reset, same-edge refill, starvation and mid-operation reset.
// ----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [3:0]   fuValid;
    logic [3:0]   fuReady;
    cdb_req_arr_t fuResult;
    cdb_t         cdb;
    logic [3:0]   cdbGrant;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] valid;
        logic       flush;
        logic [5:0] tag;
        logic [3:0] expReady;
        logic       expValid;
        logic [3:0] expGrant;
        logic [5:0] expRob;
    } vec_t;

    vec_t vecs [14];

    cdb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fu_valid  (fuValid),
        .fu_ready  (fuReady),
        .fu_result (fuResult),
        .cdb       (cdb),
        .cdb_grant (cdbGrant)
    );

    // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop so a hung run still reports itself.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Packet derived from its ROB tag; the valid field is deliberately
    // INVALID so the DUT must set it on broadcast.
    function automatic cdb_t mkPacket(input logic [5:0] rob);
        cdb_t p;
        p.valid    = INVALID;
        p.rob_addr = rob;
        p.rd_paddr = 7'(rob) + 7'd1;
        p.rd_data  = 32'hA500_0000 | 32'(rob);
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkCdb(input string name, input logic expValid,
                            input logic [3:0] expGrant, input logic [5:0] expRob);
        cdb_t e;
        e = mkPacket(expRob);
        checkOutput({name, ".valid"}, 32'(cdb.valid), 32'(expValid));
        checkOutput({name, ".grant"}, 32'(cdbGrant), 32'(expGrant));
        if (expValid) begin
            checkOutput({name, ".rob"},   32'(cdb.rob_addr), 32'(e.rob_addr));
            checkOutput({name, ".paddr"}, 32'(cdb.rd_paddr), 32'(e.rd_paddr));
            checkOutput({name, ".data"},  cdb.rd_data,       e.rd_data);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic fl,
                                 input logic [5:0] tag);
        fuValid = valid;
        flush   = fl;
        for (int u = 0; u < 4; u++) begin
            fuResult[u] = mkPacket(6'(tag + 6'(u)));
        end
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Main directed sequence.
    initial begin
        int   arithCount;
        int   mulAcceptCycle;
        int   mulSeenCycle;
        logic mulPending;
        logic [5:0] arithRob;
        logic [5:0] arithExp;
        logic [3:0] acc;

        vecs[0]  = '{4'b1111, 1'b0, 6'd8,  4'b1111, 1'b0, 4'b0000, 6'd0};
        vecs[1]  = '{4'b0000, 1'b0, 6'd0,  4'b0001, 1'b1, 4'b0001, 6'd8};
        vecs[2]  = '{4'b0000, 1'b0, 6'd0,  4'b0011, 1'b1, 4'b0010, 6'd9};
        vecs[3]  = '{4'b0000, 1'b0, 6'd0,  4'b0111, 1'b1, 4'b0100, 6'd10};
        vecs[4]  = '{4'b0000, 1'b0, 6'd0,  4'b1111, 1'b1, 4'b1000, 6'd11};
        vecs[5]  = '{4'b0000, 1'b0, 6'd0,  4'b1111, 1'b0, 4'b0000, 6'd0};
        vecs[6]  = '{4'b0001, 1'b0, 6'd20, 4'b1111, 1'b0, 4'b0000, 6'd0};
        vecs[7]  = '{4'b0110, 1'b0, 6'd16, 4'b1111, 1'b1, 4'b0001, 6'd20};
        vecs[8]  = '{4'b0110, 1'b1, 6'd24, 4'b0000, 1'b0, 4'b0000, 6'd0};
        vecs[9]  = '{4'b0000, 1'b0, 6'd0,  4'b1111, 1'b0, 4'b0000, 6'd0};
        vecs[10] = '{4'b0011, 1'b0, 6'd32, 4'b1111, 1'b0, 4'b0000, 6'd0};
        vecs[11] = '{4'b0000, 1'b0, 6'd0,  4'b1101, 1'b1, 4'b0001, 6'd32};
        vecs[12] = '{4'b0000, 1'b0, 6'd0,  4'b1111, 1'b1, 4'b0010, 6'd33};
        vecs[13] = '{4'b0000, 1'b0, 6'd0,  4'b1111, 1'b0, 4'b0000, 6'd0};

        // Reset held with all units requesting
        rst = 1'b1;
        applyStimulus(4'b1111, 1'b0, 6'd1);
        stepEdge();
        stepEdge();
        checkOutput("reset.ready", 32'(fuReady), 32'h0);
        checkOutput("reset.cdbValid", 32'(cdb.valid), 32'h0);
        checkOutput("reset.grant", 32'(cdbGrant), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("release.ready", 32'(fuReady), 32'hF);
        fuValid = 4'b0000;

        // Table: round robin over all four, flush, pointer reset by flush
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].flush, vecs[i].tag);
            #1;
            checkOutput($sformatf("vec%0d.ready", i), 32'(fuReady), 32'(vecs[i].expReady));
            stepEdge();
            checkCdb($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expGrant, vecs[i].expRob);
        end

        // Single ARITH result with specific fields
        fuValid = 4'b0001;
        fuResult[0].valid    = INVALID;
        fuResult[0].rob_addr = 6'd3;
        fuResult[0].rd_paddr = 7'd5;
        fuResult[0].rd_data  = 32'hDEADBEEF;
        stepEdge();
        fuValid = 4'b0000;
        checkOutput("single.k.valid", 32'(cdb.valid), 32'h0);
        stepEdge();
        checkOutput("single.valid", 32'(cdb.valid), 32'h1);
        checkOutput("single.grant", 32'(cdbGrant), 32'h1);
        checkOutput("single.rob", 32'(cdb.rob_addr), 32'd3);
        checkOutput("single.paddr", 32'(cdb.rd_paddr), 32'd5);
        checkOutput("single.data", cdb.rd_data, 32'hDEADBEEF);
        stepEdge();
        checkOutput("single.after.valid", 32'(cdb.valid), 32'h0);

        // Slot 3 granted while refilled on the same edge
        fuValid = 4'b1000;
        fuResult[3] = mkPacket(6'd6);
        stepEdge();
        fuResult[3] = mkPacket(6'd7);
        #1;
        checkOutput("refill.ready", 32'(fuReady), 32'hF);
        stepEdge();
        fuValid = 4'b0000;
        checkCdb("refill.old", 1'b1, 4'b1000, 6'd6);
        stepEdge();
        checkCdb("refill.new", 1'b1, 4'b1000, 6'd7);
        stepEdge();
        checkCdb("refill.idle", 1'b0, 4'b0000, 6'd0);

        // ARITH streams while MUL_DIV presents once
        arithCount     = 0;
        mulAcceptCycle = -1;
        mulSeenCycle   = -1;
        mulPending     = 1'b1;
        arithRob       = 6'd40;
        arithExp       = 6'd40;
        for (int c = 0; c < 9; c++) begin
            fuValid     = {mulPending, 2'b00, 1'b1};
            fuResult[0] = mkPacket(arithRob);
            fuResult[3] = mkPacket(6'd50);
            #1;
            acc = fuValid & fuReady;
            stepEdge();
            if (acc[0]) arithRob = arithRob + 6'd1;
            if (acc[3]) begin
                mulPending     = 1'b0;
                mulAcceptCycle = c;
            end
            if (cdbGrant == 4'b0001) begin
                arithCount++;
                checkCdb($sformatf("stream%0d.arith", c), 1'b1, 4'b0001, arithExp);
                arithExp = arithExp + 6'd1;
            end else if (cdbGrant == 4'b1000) begin
                mulSeenCycle = c;
                checkCdb($sformatf("stream%0d.mul", c), 1'b1, 4'b1000, 6'd50);
            end
        end
        fuValid = 4'b0000;
        checkOutput("stream.mulAccepted", 32'(mulAcceptCycle >= 0), 32'h1);
        checkOutput("stream.mulWithin4",
                    32'(mulSeenCycle >= 0 && mulSeenCycle - mulAcceptCycle <= 4), 32'h1);
        checkOutput("stream.arithAtLeast4", 32'(arithCount >= 4), 32'h1);
        stepEdge();
        stepEdge();

        // Reset mid-operation drops pending results immediately
        applyStimulus(4'b0110, 1'b0, 6'd60);
        stepEdge();
        fuValid = 4'b0000;
        stepEdge();
        checkCdb("midrst.pre", 1'b1, 4'b0010, 6'd61);
        rst = 1'b1;
        #1;
        checkOutput("midrst.valid", 32'(cdb.valid), 32'h0);
        checkOutput("midrst.grant", 32'(cdbGrant), 32'h0);
        checkOutput("midrst.ready", 32'(fuReady), 32'h0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midrst.readyAfter", 32'(fuReady), 32'hF);
        stepEdge();
        checkCdb("midrst.lost", 1'b0, 4'b0000, 6'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Schedules the single common data bus (cdb_t) between the four functional-unit classes: ARITH_UNIT, MEM_UNIT, BR_UNIT and MUL_DIV_UNIT.
- Each unit hands its completed result to a private one-entry holding slot through a valid/ready handshake.
- Each cycle the arbiter grants one occupied slot, round-robin, and drives it onto a registered CDB output.
- The CDB output feeds the PRF, the ROB and all reservation stations.
- A pipeline flush (branch mispredict) discards every pending result.

Parameters:
NUM_REQ, 4, number of requesters; index equals funct_unit_t encoding.
REQ_IDX_WIDTH, $clog2(NUM_REQ), width of the round-robin pointer and grant index.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
flush  in  1  mispredict flush; discards all pending results.
fu_valid  in  NUM_REQ  per-unit result valid.
fu_ready  out  NUM_REQ  per-unit slot can accept this cycle.
fu_result  in  NUM_REQ x $bits(cdb_t)  per-unit result packet; the packet's valid field is ignored.
cdb  out  $bits(cdb_t)  registered broadcast; cdb.valid qualifies it.
cdb_grant  out  NUM_REQ  registered one-hot; the source of the current cdb (debug and perf).

Behaviour:
- Reset (async, rst=1):
  - slot_valid all 0; rr_ptr=0.
  - cdb all-zero, with cdb.valid=INVALID.
  - cdb_grant=0.
  - fu_ready reads 0 while rst is high.
- Handshake:
  - fu_ready[i] = ~flush & (~slot_valid[i] | grant[i]). This is combinational and must not depend on fu_valid.
  - A transfer occurs at the edge where fu_valid[i] & fu_ready[i]: slot[i] <= fu_result[i], slot_valid[i] <= 1.
  - A unit may hold fu_valid high across cycles. Its data must remain stable until accepted.
- Arbitration (combinational, every cycle):
  - When flush=0, choose the first i with slot_valid[i], scanning i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - grant is one-hot for that i, or 0 if no slot is valid or flush=1.
- On each edge with a grant at index g:
  - cdb <= slot[g] with valid=VALID; cdb_grant <= grant.
  - slot_valid[g] <= 0, unless a new transfer into g occurs on the same edge, in which case the slot holds the new packet.
  - rr_ptr <= (g+1) mod NUM_REQ.
- On each edge with no grant: cdb.valid <= INVALID (payload don't-care), cdb_grant <= 0, rr_ptr unchanged.
- Latency:
  - A result accepted at edge k is granted in cycle k+1 at the earliest and is visible on cdb after edge k+1.
  - With a free bus, throughput is one result per cycle per unit.
- Fairness:
  - A valid slot is granted within NUM_REQ cycles of becoming valid.
  - No unit is starved, including MUL_DIV while ARITH issues back-to-back.
- Flush (flush=1 at edge):
  - All slot_valid <= 0; cdb.valid <= INVALID; cdb_grant <= 0; rr_ptr <= 0.
  - No transfers are accepted, because fu_ready=0.
  - Flush takes precedence over simultaneous grants and transfers.
  - A cdb value registered before the flush edge stays visible for its one cycle. Consumers age-filter it by rob_addr.
- Reset asserted mid-operation: immediate return to reset state, with pending results lost.
- rr_ptr wrap: NUM_REQ-1 wraps to 0. For non-power-of-two NUM_REQ, an explicit modulo compare is required.

Decomposition:
- The rv32i_types package holds:
  - cdb_t;
  - funct_unit_t, whose encoding is the requester index;
  - a new localparam NUM_CDB_REQ = 4;
  - a new typedef cdb_req_arr_t = cdb_t [NUM_CDB_REQ-1:0].
- Sub-module rr_arbiter: parameterised NUM_REQ.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; it is reused later by the reservation-station issue select.
- cdb_arbiter contains the holding slots, the pointer register and the output register.

Test Plan:
1. Reset: hold rst=1 with fu_valid=4'b1111 -> cdb.valid=0, cdb_grant=0, fu_ready=0. Release rst -> fu_ready=4'b1111.
2. Single result: ARITH (i=0) presents rd_paddr=5, rd_data=32'hDEADBEEF, rob_addr=3 for one cycle at edge k -> after edge k+1, cdb.valid=1 with those fields and cdb_grant=4'b0001. After edge k+2, cdb.valid=0.
3. All four units valid on the same edge, rr_ptr=0 -> cdb_grant sequence 0001, 0010, 0100, 1000 on four consecutive cycles. fu_ready[i] stays 0 until slot i is granted.
4. ARITH valid every cycle while MUL_DIV presents once -> MUL_DIV appears on the cdb within 4 cycles of acceptance. ARITH throughput over 8 cycles is at least 4.
5. Slots 1 and 2 occupied, flush=1 for one cycle -> next cdb.valid=0 and rr_ptr=0. Both results are never broadcast, and fu_ready returns to 1111 the following cycle.
6. Slot 3 is granted while the unit presents a new packet (rob_addr=7) on the same edge -> the old packet is broadcast. The next cycle the new packet with rob_addr=7 is broadcast with no bubble or loss, provided the other units are idle.
